reg_cmd_ctrl: RTL and testbench

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

---
 rtl/reg_cmd_ctrl_if.sv | 38 +++
 rtl/reg_cmd_ctrl.sv | 154 +++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_cmd_ctrl_if
//  Purpose  : Bundle of the byte-stream, register-file and transmitter
//             signals around reg_cmd_ctrl.
//  Modports : slave  - seen by reg_cmd_ctrl (RX/RdData/TX_BUSY in,
//                      strobes, address, data and error out)
//             master - seen by the surrounding logic (mirror image)
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR       = 4
);
   logic [DATA_WIDTH-1:0] RX_P_DATA;
   logic                  RX_D_VLD;
   logic [DATA_WIDTH-1:0] RdData;
   logic                  RdData_valid;
   logic                  TX_BUSY;
   logic                  WrEn;
   logic                  RdEn;
   logic [ADDR-1:0]       Address;
   logic [DATA_WIDTH-1:0] WrData;
   logic [DATA_WIDTH-1:0] TX_P_DATA;
   logic                  TX_D_VLD;
   logic                  CMD_ERR;

   modport slave (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_BUSY,
      output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
   );

   modport master (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_BUSY,
      input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
   );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_cmd_ctrl
//  Purpose  : Decodes a received byte stream into register-file writes
//             (0xAA, addr, data) and reads (0xBB, addr); read data is
//             forwarded to the transmitter. Malformed or unexpected bytes
//             and read timeouts raise a one-cycle CMD_ERR pulse.
//  Ports    : CLK  - system clock
//             RST  - synchronous active-high reset
//             bus  - reg_cmd_ctrl_if.slave (RX byte in, register file
//                    strobes/address/data out, read data in, TX byte out)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR       = 4,
   parameter int RD_TIMEOUT = 4
) (
   input  wire             CLK,
   input  wire             RST,
   reg_cmd_ctrl_if.slave   bus
);

   localparam logic [DATA_WIDTH-1:0] c_cmd_wr = DATA_WIDTH'('hAA);
   localparam logic [DATA_WIDTH-1:0] c_cmd_rd = DATA_WIDTH'('hBB);
   localparam int                    c_to_w   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [c_to_w-1:0]     c_to_last = c_to_w'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } state_t;

   state_t                r_state, w_next_state;
   logic                  r_wr_en, w_wr_en;
   logic                  r_rd_en, w_rd_en;
   logic                  r_cmd_err, w_cmd_err;
   logic [ADDR-1:0]       r_address, w_address;
   logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
   logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data;
   logic [c_to_w-1:0]     r_to_cnt, w_to_cnt;
   logic                  w_addr_ok;

   // An address byte is legal only if every bit above the register-file
   // address range is clear.
   assign w_addr_ok = ((bus.RX_P_DATA >> ADDR) == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_cmd_err <= 1'b0;
         r_address <= '0;
         r_wr_data <= '0;
         r_tx_data <= '0;
         r_to_cnt  <= '0;
      end else begin
         r_state   <= w_next_state;
         r_wr_en   <= w_wr_en;
         r_rd_en   <= w_rd_en;
         r_cmd_err <= w_cmd_err;
         r_address <= w_address;
         r_wr_data <= w_wr_data;
         r_tx_data <= w_tx_data;
         r_to_cnt  <= w_to_cnt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
      w_cmd_err    = 1'b0;
      w_address    = r_address;
      w_wr_data    = r_wr_data;
      w_tx_data    = r_tx_data;
      w_to_cnt     = r_to_cnt;

      case (r_state)
         IDLE: begin
            if (bus.RX_D_VLD) begin
               if (bus.RX_P_DATA == c_cmd_wr)      w_next_state = WR_ADDR;
               else if (bus.RX_P_DATA == c_cmd_rd) w_next_state = RD_ADDR;
               else                                w_cmd_err    = 1'b1;
            end
         end
         WR_ADDR: begin
            if (bus.RX_D_VLD) begin
               if (w_addr_ok) begin
                  w_address    = bus.RX_P_DATA[ADDR-1:0];
                  w_next_state = WR_DATA;
               end else begin
                  w_cmd_err    = 1'b1;
                  w_next_state = IDLE;
               end
            end
         end
         WR_DATA: begin
            if (bus.RX_D_VLD) begin
               w_wr_data    = bus.RX_P_DATA;
               w_wr_en      = 1'b1;
               w_next_state = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.RX_D_VLD) begin
               if (w_addr_ok) begin
                  w_address    = bus.RX_P_DATA[ADDR-1:0];
                  w_rd_en      = 1'b1;
                  w_to_cnt     = '0;
                  w_next_state = RD_WAIT;
               end else begin
                  w_cmd_err    = 1'b1;
                  w_next_state = IDLE;
               end
            end
         end
         RD_WAIT: begin
            // A stray byte is dropped and flagged, but the wait carries on.
            if (bus.RX_D_VLD) w_cmd_err = 1'b1;
            if (bus.RdData_valid) begin
               w_tx_data    = bus.RdData;
               w_next_state = TX_SEND;
            end else if (r_to_cnt == c_to_last) begin
               w_cmd_err    = 1'b1;
               w_next_state = IDLE;
            end else begin
               w_to_cnt     = r_to_cnt + 1'b1;
            end
         end
         TX_SEND: begin
            if (bus.RX_D_VLD) w_cmd_err = 1'b1;
            if (!bus.TX_BUSY) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign bus.WrEn      = r_wr_en;
   assign bus.RdEn      = r_rd_en;
   assign bus.Address   = r_address;
   assign bus.WrData    = r_wr_data;
   assign bus.CMD_ERR   = r_cmd_err;
   assign bus.TX_P_DATA = r_tx_data;
   // Hand-off happens in the first TX_SEND cycle the transmitter is free.
   assign bus.TX_D_VLD  = (r_state == TX_SEND) && !bus.TX_BUSY;

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_cmd_ctrl
//  Purpose  : Self-checking bench for reg_cmd_ctrl. A cycle-scheduled driver
//             issues directed and random commands and queues the expected
//             strobes (with their cycle stamps); a monitor pops and compares
//             whenever WrEn, RdEn, TX_D_VLD or CMD_ERR is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_cmd_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   reg_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR(AW)) bus_if();

   reg_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR(AW), .RD_TIMEOUT(TO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_if)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } exp_t;

   exp_t q_wr[$];
   exp_t q_rd[$];
   exp_t q_tx[$];
   exp_t q_err[$];
   exp_t e_mon;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: strobe at cycle %0d with nothing expected", name, cyc);
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      if (bus_if.WrEn === 1'b1 && bus_if.RdEn === 1'b1) unexpected("wr_rd_overlap");
      if (bus_if.WrEn === 1'b1) begin
         if (q_wr.size() == 0) unexpected("wr_en");
         else begin
            e_mon = q_wr.pop_front();
            check("wr_cycle", cyc, e_mon.cyc);
            check("wr_addr", 32'(bus_if.Address), e_mon.addr);
            check("wr_data", 32'(bus_if.WrData), e_mon.data);
         end
      end
      if (bus_if.RdEn === 1'b1) begin
         if (q_rd.size() == 0) unexpected("rd_en");
         else begin
            e_mon = q_rd.pop_front();
            check("rd_cycle", cyc, e_mon.cyc);
            check("rd_addr", 32'(bus_if.Address), e_mon.addr);
         end
      end
      if (bus_if.TX_D_VLD === 1'b1) begin
         if (q_tx.size() == 0) unexpected("tx_vld");
         else begin
            e_mon = q_tx.pop_front();
            check("tx_cycle", cyc, e_mon.cyc);
            check("tx_data", 32'(bus_if.TX_P_DATA), e_mon.data);
         end
      end
      if (bus_if.CMD_ERR === 1'b1) begin
         if (q_err.size() == 0) unexpected("cmd_err");
         else begin
            e_mon = q_err.pop_front();
            check("err_cycle", cyc, e_mon.cyc);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) next_cycle();
   endtask

   // Presents one byte for one cycle; c returns the cycle it was presented in.
   task automatic send(input logic [7:0] b, output int c);
      bus_if.RX_P_DATA = b;
      bus_if.RX_D_VLD  = 1'b1;
      c = cyc;
      next_cycle();
      bus_if.RX_D_VLD  = 1'b0;
      bus_if.RX_P_DATA = 8'($urandom);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) next_cycle();
   endtask

   function automatic logic [7:0] bad_cmd();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
      return b;
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      int c;
      send(8'hAA, c); gap();
      send(a, c);     gap();
      send(d, c);
      q_wr.push_back('{c + 1, int'(a), int'(d)});
      next_cycle();
      check("addr_hold", 32'(bus_if.Address), 32'(a));
      check("wrdata_hold", 32'(bus_if.WrData), 32'(d));
   endtask

   // dly: cycles from the RdEn cycle to RdData_valid; dly >= TO means never.
   task automatic do_read(input logic [7:0] a, input logic [7:0] rd,
                          input int dly, input int busy, input bit stray);
      int c, s, m;
      send(8'hBB, c); gap();
      send(a, c);
      // now in cycle c+1: RdEn cycle, first RD_WAIT cycle
      q_rd.push_back('{c + 1, int'(a), 0});
      if (stray && (dly >= 1)) begin
         send(bad_cmd(), s);
         q_err.push_back('{s + 1, 0, 0});
      end
      if (dly >= TO) begin
         q_err.push_back('{c + 1 + TO, 0, 0});
         wait_until(c + 1 + TO);
      end else begin
         wait_until(c + 1 + dly);
         m = cyc;
         bus_if.RdData       = rd;
         bus_if.RdData_valid = 1'b1;
         bus_if.TX_BUSY      = (busy > 0);
         next_cycle();
         bus_if.RdData_valid = 1'b0;
         bus_if.RdData       = 8'($urandom);
         if (stray && busy > 0) begin
            send(8'hAA, s);
            q_err.push_back('{s + 1, 0, 0});
         end
         wait_until(m + 1 + busy);
         bus_if.TX_BUSY = 1'b0;
         q_tx.push_back('{m + 1 + busy, 0, int'(rd)});
         next_cycle();
         check("txdata_hold", 32'(bus_if.TX_P_DATA), 32'(rd));
      end
   endtask

   task automatic do_bad_cmd();
      int c;
      send(bad_cmd(), c);
      q_err.push_back('{c + 1, 0, 0});
   endtask

   task automatic do_bad_addr(input bit is_rd);
      int c;
      send(is_rd ? 8'hBB : 8'hAA, c); gap();
      send(8'($urandom_range(16, 255)), c);
      q_err.push_back('{c + 1, 0, 0});
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_wren"},   32'(bus_if.WrEn), 0);
      check({tag, "_rden"},   32'(bus_if.RdEn), 0);
      check({tag, "_addr"},   32'(bus_if.Address), 0);
      check({tag, "_wrdata"}, 32'(bus_if.WrData), 0);
      check({tag, "_txdata"}, 32'(bus_if.TX_P_DATA), 0);
      check({tag, "_txvld"},  32'(bus_if.TX_D_VLD), 0);
      check({tag, "_cmderr"}, 32'(bus_if.CMD_ERR), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c, k;
      bus_if.RX_P_DATA    = '0;
      bus_if.RX_D_VLD     = 1'b0;
      bus_if.RdData       = '0;
      bus_if.RdData_valid = 1'b0;
      bus_if.TX_BUSY      = 1'b0;
      RST = 1'b1;
      repeat (3) next_cycle();
      check_cleared("reset");
      RST = 1'b0;
      next_cycle();

      // Directed scenarios
      do_write(8'h05, 8'h3C);
      do_read(8'h02, 8'h81, 1, 0, 1'b0);
      do_read(8'h02, 8'h81, 1, 10, 1'b0);
      do_bad_cmd();
      do_bad_addr(1'b0);
      do_read(8'h01, 8'h00, TO, 0, 1'b0);
      do_read(8'h0F, 8'h5A, TO - 1, 2, 1'b1);

      // Reset mid-command, with a data byte presented in the reset cycle
      send(8'hAA, c);
      send(8'h03, c);
      RST = 1'b1;
      bus_if.RX_P_DATA = 8'h3C;
      bus_if.RX_D_VLD  = 1'b1;
      next_cycle();
      RST = 1'b0;
      bus_if.RX_D_VLD  = 1'b0;
      check_cleared("midrst");
      send(8'h77, c);
      q_err.push_back('{c + 1, 0, 0});
      next_cycle();

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         if (k <= 3)
            do_write(8'($urandom_range(0, 15)), 8'($urandom));
         else if (k <= 7)
            do_read(8'($urandom_range(0, 15)), 8'($urandom),
                    ($urandom_range(0, 4) == 0) ? TO : int'($urandom_range(0, TO - 1)),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
         else if (k == 8)
            do_bad_cmd();
         else
            do_bad_addr(1'($urandom_range(0, 1)));
         gap();
      end

      repeat (10) next_cycle();
      check("wr_pending",  q_wr.size(), 0);
      check("rd_pending",  q_rd.size(), 0);
      check("tx_pending",  q_tx.size(), 0);
      check("err_pending", q_err.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
      $fatal(1);
   end
endmodule
`default_nettype wire
